// File: rtl/ps2_send_pkg.sv
// Shared types and defaults for the PS/2 host-to-device transmitter and its line synchronizer.
package ps2_send_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Full frame: start, 8 data, parity, stop; the start bit is driven outside the shift register
  localparam int unsigned FRAME_LEN = 11;
  localparam int unsigned SHIFT_W   = FRAME_LEN - 1;

  localparam int unsigned DEF_POLL_DIV      = 64;
  localparam int unsigned DEF_INHIBIT_TICKS = 120;
  localparam int unsigned DEF_TIMEOUT_TICKS = 4095;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Poll-tick generator with tick-rate 3-tap synchronizers on the PS/2 lines and falling-edge detect.
module ps2_line_sync
  import ps2_send_pkg::*;
#(
  parameter int unsigned POLL_DIV = DEF_POLL_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic tick_c,
  output logic fall_c,
  output logic clk_s,
  output logic data_s_c
);

  localparam int unsigned DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       clk_hist;
  logic [2:0]       data_hist;

  // Free-running modulo-POLL_DIV down-counter; tick when it reaches zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= DIV_W'(POLL_DIV - 1);
    end else if (div_cnt == '0) begin
      div_cnt <= DIV_W'(POLL_DIV - 1);
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_hist  <= '1;
      data_hist <= '1;
    end else if (tick_c) begin
      clk_hist  <= {clk_hist[1:0], ps2_clk};
      data_hist <= {data_hist[1:0], ps2_data};
    end
  end

  assign tick_c   = (div_cnt == '0);
  assign fall_c   = tick_c && (clk_hist[2:1] == 2'b10);
  assign clk_s    = clk_hist[1];
  // Reads low if either of the two oldest samples is low, biasing toward seeing the ACK
  assign data_s_c = data_hist[2] & data_hist[1];

endmodule

// File: rtl/ps2_send.sv
// PS/2 host transmitter: inhibits the bus, sends one command byte clocked by the device, checks the ACK.
module ps2_send
  import ps2_send_pkg::*;
#(
  parameter int unsigned POLL_DIV      = DEF_POLL_DIV,
  parameter int unsigned INHIBIT_TICKS = DEF_INHIBIT_TICKS,
  parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned TMR_MAX = (INHIBIT_TICKS > TIMEOUT_TICKS) ? INHIBIT_TICKS : TIMEOUT_TICKS;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 2);
  localparam int unsigned BIT_W   = $clog2(FRAME_LEN);

  state_t             state, state_n;
  logic [SHIFT_W-1:0] frame, frame_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic [TMR_W-1:0]   tmr, tmr_n;
  logic               clk_oe_n, data_oe_n, done_n, err_n, busy_n, ready_n;
  logic               tick_c, fall_c, clk_s, data_s_c, timeout_c;

  ps2_line_sync #(
    .POLL_DIV (POLL_DIV)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .tick_c   (tick_c),
    .fall_c   (fall_c),
    .clk_s    (clk_s),
    .data_s_c (data_s_c)
  );

  assign timeout_c = tick_c && (tmr >= TMR_W'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      frame       <= '1;
      bit_cnt     <= '1;
      tmr         <= '1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      busy        <= 1'b0;
      tx_ready    <= 1'b1;
    end else begin
      state       <= state_n;
      frame       <= frame_n;
      bit_cnt     <= bit_n;
      tmr         <= tmr_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      tx_done     <= done_n;
      tx_err      <= err_n;
      busy        <= busy_n;
      tx_ready    <= ready_n;
    end
  end

  always_comb begin
    state_n   = state;
    frame_n   = frame;
    bit_n     = bit_cnt;
    tmr_n     = tick_c ? tmr + TMR_W'(1) : tmr;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    err_n     = 1'b0;

    case (state)
      S_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid && tx_ready) begin
          frame_n  = {1'b1, odd_parity(tx_byte), tx_byte};
          bit_n    = '0;
          clk_oe_n = 1'b1;
          state_n  = S_INHIBIT;
        end
      end
      // One extra tick absorbs the partial first poll period so the hold is never short
      S_INHIBIT: begin
        if (tick_c && (tmr == TMR_W'(INHIBIT_TICKS))) begin
          data_oe_n = 1'b1;
          state_n   = S_START;
        end
      end
      S_START: begin
        if (tick_c) begin
          clk_oe_n = 1'b0;
          state_n  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (fall_c) begin
          data_oe_n = ~frame[0];
          frame_n   = {1'b1, frame[SHIFT_W-1:1]};
          bit_n     = bit_cnt + BIT_W'(1);
          tmr_n     = '0;
          if (bit_cnt == BIT_W'(SHIFT_W - 1)) begin
            state_n = S_ACK;
          end
        end else if (timeout_c) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_ACK: begin
        if (fall_c) begin
          if (!data_s_c) begin
            state_n = S_WAIT_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end else if (timeout_c) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (tick_c && clk_s && data_s_c) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (timeout_c) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (state_n != state) begin
      tmr_n = '0;
    end
    if (state_n == S_IDLE) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
    end
    busy_n  = (state_n != S_IDLE);
    // Ready comes back one cycle after the completion pulse
    ready_n = (state_n == S_IDLE) && !done_n && !err_n;
  end

endmodule

// File: doc/ps2_send.md
PS2_SEND -- requirements
Module: ps2_send

Interface
REQ-001 Parameter POLL_DIV, default 64: clk cycles per poll tick; line sampling and all protocol timing advance only on poll ticks.
REQ-002 Parameter INHIBIT_TICKS, default 120: poll ticks the host holds ps2 clock low before the start bit (>=100 us at target clk).
REQ-003 Parameter TIMEOUT_TICKS, default 4095: maximum poll ticks waited for any device edge or line state.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 tx_valid  in  1  request to send tx_byte; accepted when tx_valid & tx_ready on a clk edge.
REQ-007 tx_byte  in  8  command byte to device.
REQ-008 tx_ready  out  1  high only in IDLE.
REQ-009 tx_done  out  1  one-clk pulse: byte sent and device ACK seen.
REQ-010 tx_err  out  1  one-clk pulse: timeout or missing ACK.
REQ-011 busy  out  1  high in every state except IDLE; the system receiver is gated off by this.
REQ-012 ps2_clk  in  1  raw PS/2 clock line, asynchronous.
REQ-013 ps2_data  in  1  raw PS/2 data line, asynchronous.
REQ-014 ps2_clk_oe  out  1  1 = drive clock line low; 0 = release (open drain).
REQ-015 ps2_data_oe  out  1  1 = drive data line low; 0 = release.

Function
REQ-016 Poll tick: free-running counter modulo POLL_DIV; tick asserted for one clk when counter is 0.
REQ-017 Input sync: on each tick, 3-bit shift registers for ps2_clk and ps2_data; device falling edge = clk history bits [2:1]==2'b10 on a tick.
REQ-018 On accept: latch frame shift register {stop=1, parity, tx_byte}, parity = odd parity = ~^tx_byte; enter INHIBIT.
REQ-019 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0; after INHIBIT_TICKS ticks assert ps2_data_oe=1 (start bit) for one tick, then release ps2_clk_oe and enter SHIFT.
REQ-020 SHIFT: on each device falling edge, ps2_data_oe = ~frame[0], shift frame right; 8 data bits LSB first, then parity, then stop (data released) -- 10 falling edges total.
REQ-021 ACK: on 11th falling edge sample synced data; 0 -> WAIT_IDLE, 1 -> tx_err pulse, go to IDLE.
REQ-022 WAIT_IDLE: wait until synced clk and data both 1, then tx_done pulse, go to IDLE.
REQ-023 Timeout counter cleared on every falling edge and state change; reaching TIMEOUT_TICKS in SHIFT, ACK or WAIT_IDLE releases both lines, pulses tx_err, goes to IDLE.
REQ-024 tx_valid while not tx_ready is ignored; tx_byte is not re-sampled after accept.
REQ-025 tx_done and tx_err never assert in the same cycle; tx_ready rises the cycle after either pulse.
REQ-026 Line driving: only ps2_clk_oe or ps2_data_oe may drive low; never drive high.

Reset
REQ-027 reset_n low: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, busy=0, tx_ready=1 after release, counters and sync registers set to all-ones (lines idle).
REQ-028 Reset mid-frame releases both lines immediately (asynchronously); no pulse is generated.

Structure
REQ-029 Shared package: state encoding (IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE), frame length constant 11, default POLL_DIV/INHIBIT_TICKS/TIMEOUT_TICKS.
REQ-030 One sub-module, ps2_line_sync: poll tick generator plus 3-tap synchronizers and falling-edge detect, reusable by the receiver.

Verification
REQ-031 Send 0xED with device model clocking at ~12 kHz -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; device ACK -> one tx_done pulse.
REQ-032 Send 0xF4 -> parity bit 0; inhibit clock-low duration >= INHIBIT_TICKS*POLL_DIV clk cycles before data goes low.
REQ-033 Send 0x00, device omits ACK (data high on 11th edge) -> tx_err pulse, both oe=0, tx_ready=1.
REQ-034 Device never clocks after start bit -> tx_err after TIMEOUT_TICKS ticks, lines released.
REQ-035 Assert reset_n low during bit 4 of 0xAA -> oe outputs 0 same cycle, no tx_done/tx_err; next send of 0xAA completes normally.
REQ-036 tx_valid held high through a frame -> exactly one byte accepted per tx_ready window; second byte starts only after tx_done.
